jk_d_counter: RTL

- WIDTH-bit register whose every bit is a JK flip-flop realised from a D flip-flop: D = (J & ~Q) | (~K & Q). This is the conversion opposite to building D from JK.
- A mode decoder generates per-bit J/K vectors for the four operations: hold, up/down count, parallel load and raw external JK drive.
- Serves as the team's reusable JK-style counter/register primitive for sequencers and divider chains.

---
 rtl/jk_d_counter_if.sv | 26 ++
 rtl/jk_d_counter.sv | 136 +++++++++++++
 2 files changed

// File: rtl/jk_d_counter_if.sv
// jk_d_counter_if: control/status bundle of the JK-style counter.
// The master side drives mode, direction, load value and raw J/K vectors;
// the slave side (the counter) returns q, qb and the terminal-count flag.
// WIDTH must match the WIDTH of the jk_d_counter instance it is bound to.
interface jk_d_counter_if #(
    parameter int WIDTH = 4
);
    logic [1:0]       mode;
    logic             up_dn;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] j_in;
    logic [WIDTH-1:0] k_in;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic             tc;

    modport master (
        output mode, up_dn, load_val, j_in, k_in,
        input  q, qb, tc
    );

    modport slave (
        input  mode, up_dn, load_val, j_in, k_in,
        output q, qb, tc
    );
endinterface

// File: rtl/jk_d_counter.sv
// jk_d_counter: WIDTH-bit register of JK flip-flops, each built from a D flop
// with D = (J & ~Q) | (~K & Q). A mode decoder turns hold / count / load /
// raw-JK requests into per-bit J/K vectors; nothing bypasses the JK cells.
//
// Build option: define JK_CNT_MODN_EN to make mode 01 count modulo MODULUS
// (and clamp out-of-range loads to 0). Without it MODULUS is only range-checked
// and the counter wraps at 2^WIDTH.
package jk_d_counter_pkg;
    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_COUNT = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_RAW   = 2'b11
    } mode_e;
endpackage

module jk_d_counter
    import jk_d_counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input logic           clk,
    input logic           rst,
    jk_d_counter_if.slave bus
);

    // Catch an illegal modulus at elaboration rather than in silicon.
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("jk_d_counter: MODULUS out of range 2..2^WIDTH");
    end

`ifdef JK_CNT_MODN_EN
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] TC_UP   = WIDTH'(MODULUS - 1);
`else
    localparam logic [WIDTH-1:0] TC_UP   = '1;
`endif

    mode_e            mode;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic [WIDTH-1:0] d_vec;
    logic             tc_c;
`ifdef JK_CNT_MODN_EN
    logic [WIDTH-1:0] n_vec;
`else
    logic             chain;
`endif

    assign mode = mode_e'(bus.mode);

    // Mode decoder: every operation is expressed purely as J/K vectors.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the case leaves it unassigned (which would infer a latch).
        j_vec = '0;
        k_vec = '0;
`ifdef JK_CNT_MODN_EN
        n_vec = '0;
`else
        chain = 1'b1;
`endif
        unique case (mode)
            MODE_HOLD: begin
                j_vec = '0;
                k_vec = '0;
            end
            MODE_COUNT: begin
`ifdef JK_CNT_MODN_EN
                // Compute the target state, then force each cell to it.
                if (bus.up_dn) begin
                    n_vec = ({1'b0, q_r} >= MOD_EXT - 1'b1) ? '0 : q_r + WIDTH'(1);
                end else begin
                    n_vec = (q_r == '0) ? TC_UP : q_r - WIDTH'(1);
                end
                j_vec = n_vec;
                k_vec = ~n_vec;
`else
                // Bit i toggles when all lower bits are 1 (up) or 0 (down).
                for (int i = 0; i < WIDTH; i++) begin
                    j_vec[i] = chain;
                    k_vec[i] = chain;
                    chain    = chain & (bus.up_dn ? q_r[i] : ~q_r[i]);
                end
`endif
            end
            MODE_LOAD: begin
`ifdef JK_CNT_MODN_EN
                n_vec = ({1'b0, bus.load_val} >= MOD_EXT) ? '0 : bus.load_val;
                j_vec = n_vec;
                k_vec = ~n_vec;
`else
                j_vec = bus.load_val;
                k_vec = ~bus.load_val;
`endif
            end
            MODE_RAW: begin
                j_vec = bus.j_in;
                k_vec = bus.k_in;
            end
            default: begin
                j_vec = '0;
                k_vec = '0;
            end
        endcase
    end

    // JK-to-D conversion: 00 hold, 01 clear, 10 set, 11 toggle.
    assign d_vec = (j_vec & ~q_r) | (~k_vec & q_r);

    // D flops holding the register state; cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state updates use non-blocking assignments so every flop
        // samples pre-edge values, independent of statement order.
        if (!rst) begin
            q_r <= '0;
        end else begin
            q_r <= d_vec;
        end
    end

    // Terminal count: only meaningful while counting, one cycle before wrap.
    always_comb begin
        tc_c = 1'b0;
        if (mode == MODE_COUNT) begin
            tc_c = bus.up_dn ? (q_r == TC_UP) : (q_r == '0);
        end
    end

    assign bus.q  = q_r;
    assign bus.qb = ~q_r;
    assign bus.tc = tc_c;

endmodule
